// File: rtl/gate_tt_sequencer.sv
// Drives all four input vectors into a 2-input gate, captures its output into a
// truth table and compares the table against an expected pattern.
module gate_tt_sequencer #(
    parameter int          HOLD_CYCLES = 2,
    parameter logic [3:0]  EXPECT      = 4'b1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       y,
    output logic       a,
    output logic       b,
    output logic       busy,
    output logic       done,
    output logic [3:0] truth_table,
    output logic       match
);

    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [1:0]    idx;
    logic [1:0]    idx_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic [3:0]    table_next;
    logic          match_next;
    logic          a_next;
    logic          b_next;
    logic          busy_next;
    logic          done_next;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and next-output logic; a/b are computed one edge ahead so they leave registered
    always_comb begin
        state_next = state;
        idx_next   = idx;
        cnt_next   = cnt;
        table_next = truth_table;
        match_next = match;
        a_next     = 1'b0;
        b_next     = 1'b0;
        busy_next  = 1'b0;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = DRIVE;
                    idx_next   = 2'd0;
                    cnt_next   = '0;
                    table_next = 4'b0000;
                    match_next = 1'b0;
                    busy_next  = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            DRIVE: begin
                busy_next = 1'b1;
                a_next    = idx[1];
                b_next    = idx[0];
                if (cnt < HOLD_LAST) begin
                    cnt_next = cnt + CW'(1);
                end else begin
                    cnt_next        = '0;
                    table_next[idx] = y;
                    if (idx != 2'd3) begin
                        idx_next = idx + 2'd1;
                        a_next   = idx_next[1];
                        b_next   = idx_next[0];
                    end else begin
                        state_next = DONE;
                        busy_next  = 1'b0;
                        a_next     = 1'b0;
                        b_next     = 1'b0;
                        done_next  = 1'b1;
                        match_next = (table_next == EXPECT);
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            idx         <= 2'd0;
            cnt         <= '0;
            truth_table <= 4'b0000;
            match       <= 1'b0;
            a           <= 1'b0;
            b           <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            idx         <= idx_next;
            cnt         <= cnt_next;
            truth_table <= table_next;
            match       <= match_next;
            a           <= a_next;
            b           <= b_next;
            busy        <= busy_next;
            done        <= done_next;
        end
    end

endmodule

// File: tb/tb_gate_tt_sequencer.sv
// Directed bench: one sequencer with HOLD_CYCLES=2 around an AND gate that can be
// forced stuck-at-1, and one with HOLD_CYCLES=1 for back-to-back runs.
module tb_gate_tt_sequencer;

    logic       clk;
    logic       rst2, start2, y2, a2, b2, busy2, done2, match2;
    logic [3:0] tt2;
    logic       rst1, start1, y1, a1, b1, busy1, done1, match1;
    logic [3:0] tt1;
    logic       stuck;
    int         checks;
    int         errors;

    gate_tt_sequencer #(.HOLD_CYCLES(2), .EXPECT(4'b1000)) u_h2 (
        .clk(clk), .rst(rst2), .start(start2), .y(y2),
        .a(a2), .b(b2), .busy(busy2), .done(done2),
        .truth_table(tt2), .match(match2)
    );

    gate_tt_sequencer #(.HOLD_CYCLES(1), .EXPECT(4'b1000)) u_h1 (
        .clk(clk), .rst(rst1), .start(start1), .y(y1),
        .a(a1), .b(b1), .busy(busy1), .done(done1),
        .truth_table(tt1), .match(match1)
    );

    assign y2 = stuck ? 1'b1 : (a2 & b2);
    assign y1 = a1 & b1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One H=2 run from the start edge; optionally re-pulses start at cycles 3 and 5.
    task automatic run_h2(input logic [3:0] exp_tt, input logic exp_match, input bit repulse);
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("h2_ab_c%0d", k), {2'b00, a2, b2}, 4'(k / 2));
            check($sformatf("h2_busy_c%0d", k), {3'b000, busy2}, 4'd1);
            check($sformatf("h2_done_c%0d", k), {3'b000, done2}, 4'd0);
            start2 = (repulse && (k == 2 || k == 4)) ? 1'b1 : 1'b0;
            tick();
        end
        start2 = 1'b0;
        check("h2_done_c8", {3'b000, done2}, 4'd1);
        check("h2_busy_c8", {3'b000, busy2}, 4'd0);
        check("h2_ab_c8", {2'b00, a2, b2}, 4'd0);
        check("h2_table", tt2, exp_tt);
        check("h2_match", {3'b000, match2}, {3'b000, exp_match});
        tick();
        check("h2_done_c9", {3'b000, done2}, 4'd0);
        tick();
        check("h2_busy_c10", {3'b000, busy2}, 4'd0);
        check("h2_table_held", tt2, exp_tt);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        stuck  = 1'b0;
        rst2   = 1'b1;
        start2 = 1'b1;
        rst1   = 1'b1;
        start1 = 1'b0;

        // Reset overrides start
        tick();
        tick();
        check("rst_ab", {2'b00, a2, b2}, 4'd0);
        check("rst_busy", {3'b000, busy2}, 4'd0);
        check("rst_done", {3'b000, done2}, 4'd0);
        check("rst_match", {3'b000, match2}, 4'd0);
        check("rst_table", tt2, 4'b0000);
        rst2   = 1'b0;
        start2 = 1'b0;
        tick();
        check("idle_busy", {3'b000, busy2}, 4'd0);

        // Good AND gate
        run_h2(4'b1000, 1'b1, 1'b0);

        // Stuck-at-1 gate
        stuck = 1'b1;
        run_h2(4'b1111, 1'b0, 1'b0);
        stuck = 1'b0;

        // Start re-pulsed mid-run is ignored
        run_h2(4'b1000, 1'b1, 1'b1);

        // Reset at cycle 3 aborts the run
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        tick();
        tick();
        tick();
        rst2 = 1'b1;
        tick();
        rst2 = 1'b0;
        check("abort_ab", {2'b00, a2, b2}, 4'd0);
        check("abort_busy", {3'b000, busy2}, 4'd0);
        check("abort_done", {3'b000, done2}, 4'd0);
        check("abort_table", tt2, 4'b0000);
        check("abort_match", {3'b000, match2}, 4'd0);
        for (int k = 0; k < 8; k++) begin
            tick();
            check($sformatf("abort_nodone_%0d", k), {2'b00, done2, busy2}, 4'd0);
        end
        run_h2(4'b1000, 1'b1, 1'b0);

        // H=1, start held high: done after edges 4, 10, 16 counted from acceptance
        rst1 = 1'b0;
        tick();
        start1 = 1'b1;
        tick();
        for (int c = 0; c < 18; c++) begin
            if (c < 4) begin
                check($sformatf("h1_ab_c%0d", c), {2'b00, a1, b1}, 4'(c));
            end
            check($sformatf("h1_done_c%0d", c), {3'b000, done1},
                  (c == 4 || c == 10 || c == 16) ? 4'd1 : 4'd0);
            if (c == 4 || c == 10 || c == 16) begin
                check($sformatf("h1_table_c%0d", c), tt1, 4'b1000);
                check($sformatf("h1_match_c%0d", c), {3'b000, match1}, 4'd1);
            end
            tick();
        end
        start1 = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
